// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
// The popcount helper backs the optional GRAY_SEQ_CHECK_EN transition checker.
package gray_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Number of differing bits between two codes; callers zero-extend to 32 bits.
  function automatic int unsigned popcount_xor(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    int unsigned c;
    x = a ^ b;
    c = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      c += 32'(x[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Control and valid/ready stream bundle of the Gray-code sequencer.
// gray_err exists only when GRAY_SEQ_CHECK_EN is defined.
interface gray_seq_ctrl_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             dir;
  logic [N-1:0]     start_val;
  logic [CNT_W-1:0] run_len;
  logic             abort;
  logic [N-1:0]     out_gray;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
`ifdef GRAY_SEQ_CHECK_EN
  logic             gray_err;
`endif

  modport master (
    output start, dir, start_val, run_len, abort, out_ready,
    input  out_gray, out_valid, busy, done
`ifdef GRAY_SEQ_CHECK_EN
    , input gray_err
`endif
  );

  modport slave (
    input  start, dir, start_val, run_len, abort, out_ready,
    output out_gray, out_valid, busy, done
`ifdef GRAY_SEQ_CHECK_EN
    , output gray_err
`endif
  );

endinterface

// File: rtl/gray_seq_ctrl_b2g.sv
// Combinational binary-to-Gray converter: MSB passes through, other bits XOR with their upper neighbour.
module binary_to_gray #(
  parameter int N = 4
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code run sequencer: counts up/down from a loaded value and streams codes over valid/ready.
// Optional transition checker enabled by defining GRAY_SEQ_CHECK_EN.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  gray_seq_ctrl_if.slave  bus
);
  state_t           state_q, state_d;
  logic [N-1:0]     bin_q, bin_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             load;
  logic             xfer;
  logic [N-1:0]     gray;

  assign xfer = (state_q == RUN) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort masks start; a zero-length request only reports completion
        if (bus.start && !bus.abort) begin
          if (bus.run_len != '0) begin
            load    = 1'b1;
            bin_d   = bus.start_val;
            rem_d   = bus.run_len;
            dir_d   = bus.dir;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d = rem_q - CNT_W'(1);
            bin_d = (dir_q == DIR_DOWN) ? bin_q - N'(1) : bin_q + N'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  binary_to_gray #(.N(N)) u_b2g (
    .bin  (bin_q),
    .gray (gray)
  );

  assign bus.out_gray  = gray;
  assign bus.out_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;

`ifdef GRAY_SEQ_CHECK_EN
  logic [N-1:0] prev_q;
  logic         have_prev_q;
  logic         err_q;

  // Comparison spans only transfers of the current run; a new start rearms it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (load) begin
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (xfer) begin
      if (have_prev_q && (popcount_xor(32'(prev_q), 32'(gray)) != 1)) begin
        err_q <= 1'b1;
      end
      prev_q      <= gray;
      have_prev_q <= 1'b1;
    end
  end

  assign bus.gray_err = err_q;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: stimulus queues expected codes, a negedge monitor checks transfers.
module tb_gray_seq_ctrl;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_seq_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  gray_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_done = 0;
  int unsigned seen_done = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the expected queue.
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_gray  = '0;
  logic         prev_done  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && bus.out_valid) check("stall_hold", 32'(bus.out_gray), 32'(prev_gray));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("unexpected_xfer", 32'(bus.out_gray), 32'hFFFF_FFFF);
          else check("xfer_code", 32'(bus.out_gray), 32'(exp_q.pop_front()));
        end
        if (bus.done) begin
          seen_done++;
          if (prev_done) check("done_one_cycle", 32'(1), 32'(0));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_gray  = bus.out_gray;
      prev_done  = bus.done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for three cycles early in the run
  task automatic do_run(input logic [N-1:0] sv, input int unsigned len, input logic d,
                        input int mode, input int abort_at);
    int unsigned  xfers = 0;
    int unsigned  cyc   = 0;
    logic [N-1:0] b     = sv;
    logic         aborting;
    aborting = (abort_at >= 0) && (abort_at < int'(len));
    step();
    bus.start = 1'b1; bus.dir = d; bus.start_val = sv; bus.run_len = CNT_W'(len);
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    for (int unsigned k = 0; k < len; k++) begin
      exp_q.push_back(b ^ (b >> 1));
      b = d ? b - 1'b1 : b + 1'b1;
    end
    if (!aborting) exp_done++;
    step();
    bus.start = 1'b0;
    if (len == 0) begin
      bus.out_ready = 1'b1;
      repeat (3) step();
      bus.out_ready = 1'b0;
      check("zero_len_done", seen_done, exp_done);
      check("zero_len_idle", 32'(bus.busy), 32'(0));
      return;
    end
    check("start_latency_valid", 32'(bus.out_valid), 32'(1));
    check("start_latency_busy", 32'(bus.busy), 32'(1));
    while (bus.busy && cyc < 2000) begin
      bus.abort = aborting && (xfers == abort_at);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom % 2);
        default: bus.out_ready = !(cyc >= 1 && cyc <= 3);
      endcase
      // starts while running must be ignored
      bus.start = ($urandom % 4) == 0;
      bus.start_val = N'($urandom); bus.run_len = CNT_W'($urandom); bus.dir = 1'($urandom);
      if (bus.out_ready) xfers++;
      step();
      cyc++;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    check("run_timeout", 32'(cyc < 2000), 32'(1));
    if (aborting) begin
      check("abort_stops_run", 32'(xfers <= abort_at + 1), 32'(1));
      exp_q.delete();
    end else begin
      check("run_all_codes", 32'(exp_q.size()), 32'(0));
    end
    repeat (2) step();
    check("done_count", seen_done, exp_done);
    check("idle_valid_low", 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    bus.start = 1'b0; bus.dir = 1'b0; bus.start_val = '0; bus.run_len = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    repeat (2) step();
    check("reset_gray", 32'(bus.out_gray), 32'(0));
    check("reset_valid", 32'(bus.out_valid), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));
    rst = 1'b0;
    step();

    // abort while idle, and abort together with start, must not launch a run
    bus.abort = 1'b1; bus.start = 1'b1; bus.run_len = 8'd5; bus.out_ready = 1'b1;
    repeat (2) step();
    bus.abort = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
    check("abort_start_idle", 32'(bus.busy), 32'(0));

    do_run(4'd0, 16, 1'b0, 0, -1);
`ifdef GRAY_SEQ_CHECK_EN
    check("gray_err_clean", 32'(bus.gray_err), 32'(0));
`endif
    do_run(4'd1, 4, 1'b1, 0, -1);
    do_run(4'd3, 3, 1'b0, 2, -1);
    do_run(4'd0, 10, 1'b0, 0, 3);
    do_run(4'd5, 2, 1'b0, 0, -1);
    do_run(4'd7, 0, 1'b0, 0, -1);
    do_run(4'd14, 20, 1'b0, 1, -1);

    // synchronous reset in the middle of a run
    step();
    bus.start = 1'b1; bus.start_val = 4'd9; bus.run_len = 8'd20; bus.dir = 1'b0;
    step();
    bus.start = 1'b0; bus.out_ready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) exp_q.push_back(4'd9 + 4'(k) ^ ((4'd9 + 4'(k)) >> 1));
    repeat (3) step();
    rst = 1'b1; bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    check("rst_mid_gray", 32'(bus.out_gray), 32'(0));
    check("rst_mid_valid", 32'(bus.out_valid), 32'(0));
    check("rst_mid_busy", 32'(bus.busy), 32'(0));
    check("rst_mid_queue", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    step();

    for (int unsigned r = 0; r < 40; r++) begin
      int unsigned len;
      int          ab;
      len = $urandom_range(0, 40);
      ab  = ($urandom % 4 == 0) ? int'($urandom_range(0, 40)) : -1;
      do_run(N'($urandom), len, 1'($urandom), 1, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
